bcd_countdown_timer: RTL and testbench

- Parametrised N-digit BCD timer with a prescaled tick, a run/pause toggle, a load port and a registered 7-segment drive per digit.
- Counts down from a preset to zero, or up from zero to the preset. Flags expiry with a one-cycle done pulse and a sticky expired flag.
- Sits between board switches/keys and the HEX displays. It is the general timer used by lab tops in place of per-lab fixed two-digit counters.

---
 rtl/bcd_countdown_timer.sv | 219 +++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD up/down timer with prescaled step, run/pause toggle, load port
// and a registered active-low 7-segment drive per digit.
module bcd_countdown_timer #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50000000,
    parameter int PRE_W    = 32
) (
    input  logic                  clkin,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  up_mode,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    localparam int CW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                r[4*k +: 4] = 4'd9;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        logic [3:0]    d;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d      = 4'd9;
                    borrow = 1'b1;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                borrow = 1'b0;
            end
            r[4*k +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        logic [3:0]    d;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    d     = 4'd0;
                    carry = 1'b1;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
            r[4*k +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [SW-1:0] seg_all(input logic [CW-1:0] v);
        logic [SW-1:0] r;
        r = {SW{1'b1}};
        for (int k = 0; k < DIGITS; k++) begin
            r[7*k +: 7] = seg_digit(v[4*k +: 4]);
        end
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    target_r;
    logic             mode_up_r;
    logic [PRE_W-1:0] pre_r;
    logic             start_q_r;
    logic             done_r;
    logic [SW-1:0]    seg_r;

    logic [CW-1:0]    stepped_s;
    logic [CW-1:0]    term_s;
    logic [CW-1:0]    load_clamped_s;
    logic             start_edge_s;
    logic             tick_s;

    assign term_s         = mode_up_r ? target_r : {CW{1'b0}};
    assign load_clamped_s = clamp_bcd(load_value);
    assign start_edge_s   = start & ~start_q_r;
    assign tick_s         = (state_r == ST_RUN) && (pre_r == PRE_LAST);

    // Next count value for one step in the current direction.
    always_comb begin
        stepped_s = count_r;
        if (mode_up_r) begin
            stepped_s = bcd_inc(count_r);
        end else begin
            stepped_s = bcd_dec(count_r);
        end
    end

    // Control FSM, prescaler and count; priority reset > load > start edge > tick.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= {CW{1'b0}};
            target_r  <= {CW{1'b0}};
            mode_up_r <= 1'b0;
            pre_r     <= {PRE_W{1'b0}};
            start_q_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            start_q_r <= start;
            done_r    <= 1'b0;
            if (load) begin
                target_r  <= load_clamped_s;
                mode_up_r <= up_mode;
                count_r   <= up_mode ? {CW{1'b0}} : load_clamped_s;
                pre_r     <= {PRE_W{1'b0}};
                state_r   <= ST_IDLE;
            end else if (start_edge_s && (state_r != ST_EXPIRED)) begin
                // A pause edge freezes the prescaler, even on a tick cycle.
                case (state_r)
                    ST_IDLE: begin
                        if (count_r == term_s) begin
                            state_r <= ST_EXPIRED;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_RUN:    state_r <= ST_PAUSED;
                    ST_PAUSED: state_r <= ST_RUN;
                    default:   state_r <= state_r;
                endcase
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (tick_s) begin
                            pre_r   <= {PRE_W{1'b0}};
                            count_r <= stepped_s;
                            if (stepped_s == term_s) begin
                                state_r <= ST_EXPIRED;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end else begin
                            pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_PAUSED: pre_r <= pre_r;
                    default:   pre_r <= {PRE_W{1'b0}};
                endcase
            end
        end
    end

    // Segment drive lags count by one cycle.
    always_ff @(posedge clkin) begin
        if (reset) begin
            seg_r <= seg_all({CW{1'b0}});
        end else begin
            seg_r <= seg_all(count_r);
        end
    end

    assign count   = count_r;
    assign seg     = seg_r;
    assign done    = done_r;
    assign running = (state_r == ST_RUN);
    assign expired = (state_r == ST_EXPIRED);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: a table of load/run scenarios plus
// hand-written pause, load-while-running, reset and multi-digit sequences.
module tb_bcd_countdown_timer;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;

    logic        clkin = 1'b0;
    logic        reset;
    logic        load, up_mode, start;
    logic [7:0]  load_value;
    logic [7:0]  count;
    logic [13:0] seg;
    logic        running, done, expired;

    logic        load4, up_mode4, start4;
    logic [15:0] load_value4;
    logic [15:0] count4;
    logic [27:0] seg4;
    logic        running4, done4, expired4;

    int checks = 0;
    int errors = 0;

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(4), .PRE_W(8)) dut (
        .clkin(clkin), .reset(reset), .load(load), .load_value(load_value),
        .up_mode(up_mode), .start(start), .count(count), .seg(seg),
        .running(running), .done(done), .expired(expired)
    );

    bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(2), .PRE_W(4)) dut4 (
        .clkin(clkin), .reset(reset), .load(load4), .load_value(load_value4),
        .up_mode(up_mode4), .start(start4), .count(count4), .seg(seg4),
        .running(running4), .done(done4), .expired(expired4)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [7:0]  value;
        logic        up;
        logic [7:0]  exp_load;
        logic [7:0]  exp_term;
        int          steps;
        logic [13:0] exp_seg;
    } vec_t;

    vec_t vecs [6];

    task automatic cyc();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int m);
        logic [7:0] r;
        r[7:4] = 4'(m / 10);
        r[3:0] = 4'(m % 10);
        return r;
    endfunction

    initial begin
        int  m;
        bit  hit;

        vecs[0] = '{8'h12, 1'b0, 8'h12, 8'h00, 12, {S0, S0}};
        vecs[1] = '{8'h05, 1'b1, 8'h00, 8'h05, 5,  {S0, S5}};
        vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00, 0,  {S0, S0}};
        vecs[3] = '{8'h10, 1'b1, 8'h00, 8'h10, 10, {S1, S0}};
        vecs[4] = '{8'h3F, 1'b0, 8'h39, 8'h00, 39, {S0, S0}};
        vecs[5] = '{8'hA2, 1'b1, 8'h00, 8'h92, 92, {S9, S2}};

        reset = 1'b1; load = 1'b0; up_mode = 1'b0; start = 1'b0; load_value = 8'h00;
        load4 = 1'b0; up_mode4 = 1'b0; start4 = 1'b0; load_value4 = 16'h0000;
        cyc();
        cyc();
        reset = 1'b0;
        chk("reset_count", 32'(count), 32'h00);
        chk("reset_seg", 32'(seg), 32'({S0, S0}));
        chk("reset_flags", {29'd0, running, done, expired}, 32'd0);

        // Scenario table: load, start, follow every cycle to expiry.
        for (int v = 0; v < 6; v++) begin
            load = 1'b1; load_value = vecs[v].value; up_mode = vecs[v].up; start = 1'b0;
            cyc();
            load = 1'b0;
            chk("load_count", 32'(count), 32'(vecs[v].exp_load));
            chk("load_flags", {29'd0, running, done, expired}, 32'd0);
            start = 1'b1;
            cyc();
            if (vecs[v].steps == 0) begin
                chk("imm_flags", {29'd0, running, done, expired}, 32'b011);
                cyc();
                chk("imm_done_drop", {29'd0, running, done, expired}, 32'b001);
            end else begin
                m = bcd2int(vecs[v].exp_load);
                chk("run_entry", {31'd0, running}, 32'd1);
                for (int i = 1; i <= 4 * vecs[v].steps; i++) begin
                    cyc();
                    if (i % 4 == 0) m = vecs[v].up ? m + 1 : m - 1;
                    checks++;
                    if (count !== int2bcd(m)) begin
                        errors++;
                        $display("FAIL step_count v=%0d cyc=%0d actual=%h required=%h", v, i, count, int2bcd(m));
                    end
                    if (i == 4 * vecs[v].steps)
                        chk("expire_flags", {29'd0, running, done, expired}, 32'b011);
                    else
                        chk("run_flags", {29'd0, running, done, expired}, 32'b100);
                end
                cyc();
                chk("done_drop", {29'd0, running, done, expired}, 32'b001);
            end
            chk("term_count", 32'(count), 32'(vecs[v].exp_term));
            chk("term_seg", 32'(seg), 32'(vecs[v].exp_seg));
            start = 1'b0;
            cyc();
            start = 1'b1;
            cyc();
            chk("expired_start_ignored", {29'd0, running, done, expired}, 32'b001);
            chk("expired_hold", 32'(count), 32'(vecs[v].exp_term));
            start = 1'b0;
        end

        // Pause mid-period, hold 20 cycles, resume finishes the partial period.
        load = 1'b1; load_value = 8'h05; up_mode = 1'b0;
        cyc();
        load = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        start = 1'b1;
        cyc();
        chk("paused_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("paused_hold", 32'(count), 32'h05);
        end
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        chk("resume_running", {31'd0, running}, 32'd1);
        chk("resume_count", 32'(count), 32'h05);
        cyc();
        chk("resume_plus1", 32'(count), 32'h05);
        cyc();
        chk("resume_plus2", 32'(count), 32'h04);
        start = 1'b0;

        // Load while running at 53 restores the clamped preset and idles.
        load = 1'b1; load_value = 8'hA7; up_mode = 1'b0;
        cyc();
        load = 1'b0;
        chk("clamp_load", 32'(count), 32'h97);
        start = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            cyc();
            if (count == 8'h53) hit = 1'b1;
        end
        chk("reach_53", {31'd0, hit}, 32'd1);
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("reload_count", 32'(count), 32'h97);
        chk("reload_flags", {29'd0, running, done, expired}, 32'd0);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        chk("rerun_step", 32'(count), 32'h96);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrun_reset_count", 32'(count), 32'h00);
        chk("midrun_reset_flags", {29'd0, running, done, expired}, 32'd0);
        chk("midrun_reset_seg", 32'(seg), 32'({S0, S0}));
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        chk("reset_mode_down", {29'd0, running, done, expired}, 32'b011);
        start = 1'b0;

        // Four digits: multi-digit borrow, then pause on a tick cycle.
        load4 = 1'b1; load_value4 = 16'h1000; up_mode4 = 1'b0;
        cyc();
        load4 = 1'b0; start4 = 1'b1;
        cyc();
        chk("d4_run", 32'(count4), 32'h1000);
        cyc();
        chk("d4_hold", 32'(count4), 32'h1000);
        cyc();
        chk("d4_borrow", 32'(count4), 32'h0999);
        start4 = 1'b0;
        cyc();
        start4 = 1'b1;
        cyc();
        chk("d4_tick_pause_count", 32'(count4), 32'h0999);
        chk("d4_tick_pause_running", {31'd0, running4}, 32'd0);
        start4 = 1'b0;
        cyc();
        start4 = 1'b1;
        cyc();
        chk("d4_resume_count", 32'(count4), 32'h0999);
        chk("d4_resume_running", {31'd0, running4}, 32'd1);
        cyc();
        chk("d4_resume_step", 32'(count4), 32'h0998);
        start4 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
